// File: rtl/eka_pkg.sv
// Shared definitions for the eka memory responder: FSM states, the fetch NOP
// and the bit positions of the sticky error vector.
package eka_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int ERR_OOR = 0;
  localparam int ERR_MIS = 1;
  localparam int ERR_OVF = 2;

endpackage

// File: rtl/eka_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; flush emits any
// partial word zero-padded and restarts the byte count.
module eka_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  input  logic        flush,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q;
  logic [23:0] buf_q;

  function automatic logic [23:0] pad_mask(input logic [1:0] cnt);
    case (cnt)
      2'd1:    pad_mask = 24'h0000ff;
      2'd2:    pad_mask = 24'h00ffff;
      2'd3:    pad_mask = 24'hffffff;
      default: pad_mask = 24'h000000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 2'd0;
    end else if (flush) begin
      cnt_q <= 2'd0;
    end else if (byte_valid) begin
      cnt_q <= cnt_q + 2'd1;
    end
  end

  // Byte lanes carry no reset; stale lanes are masked off on flush.
  always_ff @(posedge clk) begin
    if (byte_valid && !flush) begin
      case (cnt_q)
        2'd0:    buf_q[7:0]   <= byte_in;
        2'd1:    buf_q[15:8]  <= byte_in;
        2'd2:    buf_q[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    word_valid = 1'b0;
    word       = {byte_in, buf_q};
    if (flush) begin
      word_valid = (cnt_q != 2'd0);
      word       = {8'h00, buf_q & pad_mask(cnt_q)};
    end else if (byte_valid && cnt_q == 2'd3) begin
      word_valid = 1'b1;
    end
  end

endmodule

// File: rtl/eka_mem_responder.sv
// Unified instruction/data memory for a small core: loads a program image
// from a byte stream while holding the core in reset, then serves fetches,
// loads and stores from one shared array.
module eka_mem_responder
  import eka_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [31:0]           instruction,
  input  logic [31:0]           data_addr,
  input  logic [31:0]           mem_wr_data,
  input  logic                  mem_wr,
  input  logic                  mem_rd,
  output logic [31:0]           mem_rd_data,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_byte,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  core_reset,
  output logic [2:0]            err
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int PW = IW + 1;
  localparam logic [ADDR_WIDTH-1:0] I_LIMIT = ADDR_WIDTH'(DEPTH_WORDS * 4);
  localparam logic [31:0]           D_LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [PW-1:0]         PTR_FULL = PW'(DEPTH_WORDS);

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q;
  logic [2:0]    err_q, err_set;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          run, ptr_full, ld_accept, ld_drop, pk_valid, pk_flush;
  logic [31:0]   pk_word;
  logic          pk_word_valid, ld_we, st_we;
  logic          i_oor, d_oor, d_mis, d_acc;
  logic [IW-1:0] i_idx, d_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ld_ready   = 1'b0;
    core_reset = 1'b1;
    case (state_q)
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid && ld_last) state_d = FLUSH;
      end
      FLUSH: state_d = RUN;
      RUN:   core_reset = 1'b0;
      default: state_d = LOAD;
    endcase
  end

  // Loader path: bytes beyond the end of the array are dropped, not wrapped.
  assign run       = (state_q == RUN);
  assign ptr_full  = (ptr_q == PTR_FULL);
  assign ld_accept = (state_q == LOAD) && ld_valid;
  assign ld_drop   = ld_accept && ptr_full;
  assign pk_valid  = ld_accept && !ptr_full;
  assign pk_flush  = (state_q == FLUSH);
  assign ld_we     = pk_word_valid && !ptr_full;

  eka_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (pk_valid),
    .byte_in    (ld_byte),
    .flush      (pk_flush),
    .word       (pk_word),
    .word_valid (pk_word_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (ld_we) begin
      ptr_q <= ptr_q + PW'(1);
    end
  end

  // Core ports: both read combinationally from the same array.
  assign i_idx = inst_addr[IW+1:2];
  assign d_idx = data_addr[IW+1:2];
  assign i_oor = (inst_addr >= I_LIMIT);
  assign d_oor = (data_addr >= D_LIMIT);
  assign d_mis = (data_addr[1:0] != 2'b00);
  assign d_acc = mem_rd || mem_wr;
  assign st_we = run && mem_wr && !d_oor && !d_mis;

  assign instruction = (run && !i_oor) ? mem[i_idx] : NOP;
  assign mem_rd_data = (run && mem_rd && !d_oor) ? mem[d_idx] : 32'h0;

  // Loader writes and core stores live in disjoint states, so one port suffices.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ptr_q[IW-1:0]] <= pk_word;
    end else if (st_we) begin
      mem[d_idx] <= mem_wr_data;
    end
  end

  always_comb begin
    err_set          = '0;
    err_set[ERR_OVF] = ld_drop;
    err_set[ERR_MIS] = run && d_acc && d_mis;
    err_set[ERR_OOR] = run && ((d_acc && d_oor) || i_oor);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_q | err_set;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_eka_mem_responder.sv
// Bench for eka_mem_responder: program load, shared-array loads/stores/fetches,
// error flags, reset behaviour and loader overflow.
module tb_eka_mem_responder;

  localparam int AW    = 32;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] inst_addr;
  logic [31:0]   instruction;
  logic [31:0]   data_addr, mem_wr_data, mem_rd_data;
  logic          mem_wr, mem_rd;
  logic          ld_valid, ld_last, ld_ready, core_reset;
  logic [7:0]    ld_byte;
  logic [2:0]    err;

  always #5 clk = ~clk;

  eka_mem_responder #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .inst_addr   (inst_addr),
    .instruction (instruction),
    .data_addr   (data_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr      (mem_wr),
    .mem_rd      (mem_rd),
    .mem_rd_data (mem_rd_data),
    .ld_valid    (ld_valid),
    .ld_byte     (ld_byte),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .core_reset  (core_reset),
    .err         (err)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] ia;
    logic [31:0] da;
    logic        rd;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
  } vec_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic sb_push(input string name, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    exp_t e;
    if (sb.size() == 0) begin
      total_cnt++;
      $display("FAIL scoreboard_empty: got %h expected none", act);
      return;
    end
    e = sb.pop_front();
    cmp(e.name, act, e.exp);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    settle;
    if (!ld_ready) begin
      total_cnt++;
      $display("FAIL ld_ready_low: got 0 expected 1");
    end
    cyc;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    cyc;
    reset = 1'b0;
  endtask

  task automatic read_word(input string name, input logic [31:0] addr, input logic [31:0] exp);
    data_addr = addr;
    mem_rd    = 1'b1;
    sb_push(name, exp);
    settle;
    sb_pop(mem_rd_data);
    cyc;
    mem_rd = 1'b0;
  endtask

  vec_t vecs[4];
  logic [7:0] prog[8];

  initial begin
    vecs[0] = '{"run_w0",    32'h0, 32'h0, 1'b1, 32'h0000_0013, 32'h0000_0013};
    vecs[1] = '{"run_w1",    32'h4, 32'h4, 1'b1, 32'h0010_0093, 32'h0010_0093};
    vecs[2] = '{"run_rd_off", 32'h4, 32'h0, 1'b0, 32'h0010_0093, 32'h0000_0000};
    vecs[3] = '{"run_cross", 32'h0, 32'h4, 1'b1, 32'h0000_0013, 32'h0010_0093};
    prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    reset = 1'b1;
    inst_addr = 32'h4; data_addr = '0; mem_wr_data = '0;
    mem_wr = 1'b0; mem_rd = 1'b1;
    ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
    repeat (2) cyc;
    settle;
    cmp("rst_core_reset", {31'b0, core_reset}, 32'd1);
    cmp("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
    cmp("rst_err", {29'b0, err}, 32'd0);
    cmp("load_nop", instruction, 32'h0000_0013);
    cmp("load_rd_zero", mem_rd_data, 32'h0);
    cyc;
    reset = 1'b0;
    mem_rd = 1'b0;
    cyc;

    // Program image with an idle gap mid-word.
    for (int i = 0; i < 8; i++) begin
      if (i == 3) repeat (3) cyc;
      send_byte(prog[i], i == 7);
    end
    settle;
    cmp("flush_core_reset", {31'b0, core_reset}, 32'd1);
    cmp("flush_nop", instruction, 32'h0000_0013);
    cyc;
    settle;
    cmp("run_core_reset", {31'b0, core_reset}, 32'd0);
    cmp("run_ld_ready", {31'b0, ld_ready}, 32'd0);
    cyc;

    for (int i = 0; i < 4; i++) begin
      inst_addr = vecs[i].ia;
      data_addr = vecs[i].da;
      mem_rd    = vecs[i].rd;
      sb_push({vecs[i].name, "_instr"}, vecs[i].exp_i);
      sb_push({vecs[i].name, "_data"}, vecs[i].exp_d);
      settle;
      sb_pop(instruction);
      sb_pop(mem_rd_data);
      cyc;
    end
    mem_rd = 1'b0;
    settle;
    cmp("err_clean", {29'b0, err}, 32'd0);
    cyc;

    // Store, then store+load same word: old data this cycle, new data next.
    data_addr = 32'h40; mem_wr_data = 32'h1111_1111; mem_wr = 1'b1;
    cyc;
    mem_wr_data = 32'hDEAD_BEEF; mem_rd = 1'b1; inst_addr = 32'h40;
    sb_push("rmw_old_data", 32'h1111_1111);
    sb_push("rmw_old_instr", 32'h1111_1111);
    settle;
    sb_pop(mem_rd_data);
    sb_pop(instruction);
    cyc;
    mem_wr = 1'b0;
    sb_push("rmw_new_data", 32'hDEAD_BEEF);
    sb_push("rmw_new_instr", 32'hDEAD_BEEF);
    settle;
    sb_pop(mem_rd_data);
    sb_pop(instruction);
    cyc;

    // Misaligned store is suppressed and flagged.
    mem_rd = 1'b0; data_addr = 32'h42; mem_wr_data = 32'h5555_5555; mem_wr = 1'b1;
    cyc;
    mem_wr = 1'b0; data_addr = 32'h40; mem_rd = 1'b1;
    settle;
    cmp("mis_store_suppressed", mem_rd_data, 32'hDEAD_BEEF);
    cmp("mis_err", {29'b0, err}, 32'd2);
    data_addr = 32'h43;
    #1;
    cmp("mis_load_aligned", mem_rd_data, 32'hDEAD_BEEF);
    cyc;
    mem_rd = 1'b0;

    // Fetch at the end of the array.
    inst_addr = DEPTH * 4;
    settle;
    cmp("oor_fetch_nop", instruction, 32'h0000_0013);
    cyc;
    inst_addr = 32'h0;
    settle;
    cmp("oor_fetch_err", {29'b0, err}, 32'd3);
    cyc;

    // Out-of-range store that would alias word 16 if not suppressed.
    data_addr = 32'h140; mem_wr_data = 32'h0000_0099; mem_wr = 1'b1; mem_rd = 1'b1;
    settle;
    cmp("oor_load_zero", mem_rd_data, 32'h0);
    cyc;
    mem_wr = 1'b0; mem_rd = 1'b0;
    read_word("oor_store_suppressed", 32'h40, 32'hDEAD_BEEF);

    // Asynchronous reset during RUN.
    reset = 1'b1;
    #1;
    cmp("arst_core_reset", {31'b0, core_reset}, 32'd1);
    cmp("arst_err", {29'b0, err}, 32'd0);
    cmp("arst_ld_ready", {31'b0, ld_ready}, 32'd1);
    cyc;
    reset = 1'b0;
    cyc;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    cyc;
    read_word("reload_w0", 32'h0, 32'h0403_0201);
    read_word("reload_w1_kept", 32'h4, 32'h0010_0093);
    read_word("reload_w16_kept", 32'h40, 32'hDEAD_BEEF);

    // Reset mid-load abandons the partial word; then a 5-byte image.
    pulse_reset;
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    pulse_reset;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'hEE, 1'b1);
    cyc;
    read_word("five_w0", 32'h0, 32'hDDCC_BBAA);
    read_word("five_w1_pad", 32'h4, 32'h0000_00EE);

    // Fill the whole array plus one extra byte.
    pulse_reset;
    for (int i = 0; i <= DEPTH * 4; i++) begin
      send_byte(8'(i), i == DEPTH * 4);
    end
    cyc;
    read_word("full_w0", 32'h0, 32'h0302_0100);
    read_word("full_wlast", 32'(DEPTH * 4 - 4), 32'hFFFE_FDFC);
    settle;
    cmp("ovf_err", {29'b0, err}, 32'd4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/eka_mem_responder.md
EKA_MEM_RESPONDER -- requirements
Module: eka_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of inst_addr.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: words of backing store; power of two.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-005 SHALL have port inst_addr, input, ADDR_WIDTH: core instruction byte address.
REQ-006 SHALL have port instruction, output, 32: fetched word.
REQ-007 SHALL have port data_addr, input, 32: core data byte address.
REQ-008 SHALL have port mem_wr_data, input, 32: store data.
REQ-009 SHALL have ports mem_wr and mem_rd, input, 1 each: store and load strobes.
REQ-010 SHALL have port mem_rd_data, output, 32: load data.
REQ-011 SHALL have ports ld_valid (input, 1), ld_byte (input, 8), ld_last (input, 1): program-loader byte stream.
REQ-012 SHALL have port ld_ready, output, 1: loader byte accepted when ld_valid and ld_ready.
REQ-013 SHALL have port core_reset, output, 1: hold core in reset until the image is loaded.
REQ-014 SHALL have port err, output, 3: sticky {overflow, misaligned, out_of_range}.

Function
REQ-015 SHALL implement FSM LOAD -> FLUSH -> RUN; LOAD on reset; RUN terminal until reset.
REQ-016 LOAD: ld_ready=1; accepted bytes packed little-endian (first byte -> bits 7:0) by a 2-bit byte counter; on the 4th byte the word is written at load pointer, pointer +1.
REQ-017 LOAD: accepted byte with ld_last=1 SHALL move to FLUSH next cycle; in FLUSH a partial word (counter != 0) is written zero-padded; FLUSH lasts exactly one cycle, then RUN.
REQ-018 Bytes arriving when pointer = DEPTH_WORDS SHALL be dropped and set err[2]; ld_last still advances the FSM.
REQ-019 ld_valid=0 SHALL hold packer state; no timeout.
REQ-020 core_reset SHALL be 1 in LOAD and FLUSH, 0 in RUN, transitioning combinationally on state.
REQ-021 RUN: instruction SHALL be combinational read of word inst_addr[ADDR_WIDTH-1:2]; zero-cycle latency.
REQ-022 inst_addr beyond DEPTH_WORDS*4, or any state other than RUN, SHALL return NOP 32'h0000_0013; out-of-range in RUN sets err[0].
REQ-023 RUN: mem_rd=1 SHALL return word data_addr[31:2] combinationally; mem_rd=0 returns 32'h0.
REQ-024 RUN: mem_wr=1 SHALL write mem_wr_data on the next rising edge.
REQ-025 Load and store to the same word in the same cycle SHALL return the old (pre-edge) data.
REQ-026 data_addr[1:0] != 0 with mem_rd or mem_wr SHALL set err[1]; load returns aligned word, store is suppressed.
REQ-027 data_addr out of range SHALL set err[0]; load returns 0, store suppressed.
REQ-028 Store strobes outside RUN SHALL be ignored; mem_rd_data = 0 outside RUN.
REQ-029 Instruction and data ports SHALL share one array; a store is visible to the fetch port from the next cycle.

Reset
REQ-030 Asserting reset SHALL set state=LOAD, pointer=0, byte counter=0, err=0, core_reset=1, ld_ready=1 immediately.
REQ-031 Reset mid-load or mid-run SHALL abandon the partial word; array contents are not cleared.
REQ-032 Array SHALL have no reset and be initialized only by the loader or stores.

Structure
REQ-033 Shared package eka_pkg SHALL hold state enum (LOAD, FLUSH, RUN), NOP constant, err bit indices.
REQ-034 Byte packing SHALL be sub-module eka_byte_packer (byte in, word + word_valid out, flush input).

Verification
REQ-035 Load bytes 13 00 00 00 93 00 10 00 (last on 8th) -> words 0/1 = 32'h00000013/32'h00100093; core_reset falls 2 cycles after last byte.
REQ-036 Load 5 bytes AA BB CC DD EE (last) -> word 1 = 32'h000000EE after FLUSH.
REQ-037 RUN, store 32'hDEADBEEF to 0x40 with simultaneous load of 0x40 -> old value that cycle, 32'hDEADBEEF next cycle, also on inst_addr=0x40.
REQ-038 Store to 0x42 -> word 0x40 unchanged, err=3'b010.
REQ-039 inst_addr = DEPTH_WORDS*4 -> instruction=32'h00000013, err[0]=1.
REQ-040 Assert reset during RUN -> core_reset=1 and err=0 immediately; previously loaded words still readable after reload of 4 bytes at word 0 only.
